// File: rtl/sensor_debounce_sync.sv
// sensor_debounce_sync: per-channel 2-flop synchroniser, counter debounce, edge/glitch pulses and stuck-sensor timers
module sensor_debounce_sync #(
  parameter int              N_CH        = 5,
  parameter int              DEB_CYCLES  = 16,
  parameter int              DEB_W       = 8,
  parameter int              STUCK_LIMIT = 50000,
  parameter int              STUCK_W     = 16,
  parameter logic [N_CH-1:0] RST_VAL     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] x_raw,
  input  logic            stuck_en,
  input  logic [N_CH-1:0] stuck_clr,
  output logic [N_CH-1:0] x_out,
  output logic [N_CH-1:0] x_rise,
  output logic [N_CH-1:0] x_fall,
  output logic [N_CH-1:0] glitch,
  output logic [N_CH-1:0] stuck
);
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STUCK_W-1:0] LIM      = STUCK_W'(STUCK_LIMIT);
  logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_CH-1:0] x_out_q, x_out_d, x_rise_q, x_rise_d, x_fall_q, x_fall_d;
  logic [N_CH-1:0] glitch_q, glitch_d, stuck_q, stuck_d;
  logic [N_CH-1:0] differ, accept;
  logic [N_CH-1:0][DEB_W-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0][STUCK_W-1:0] timer_q, timer_d;
  // next-state: a pending level is accepted after DEB_CYCLES disagreeing samples; agreement aborts it as a glitch
  always_comb begin
    sync1_d  = x_raw;
    sync2_d  = sync1_q;
    differ   = sync2_q ^ x_out_q;
    accept   = '0;
    x_out_d  = x_out_q;
    x_rise_d = '0;
    x_fall_d = '0;
    glitch_d = '0;
    stuck_d  = '0;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    for (int i = 0; i < N_CH; i++) begin
      accept[i]   = differ[i] && cnt_q[i] == DEB_LAST;
      cnt_d[i]    = !differ[i] || accept[i] ? '0 : cnt_q[i] + 1'b1;
      glitch_d[i] = !differ[i] && cnt_q[i] != '0;
      x_out_d[i]  = accept[i] ? sync2_q[i] : x_out_q[i];
      x_rise_d[i] = accept[i] && sync2_q[i];
      x_fall_d[i] = accept[i] && !sync2_q[i];
      timer_d[i]  = !stuck_en || stuck_clr[i] || accept[i] ? '0 :
                    timer_q[i] < LIM ? timer_q[i] + 1'b1 : timer_q[i];
      stuck_d[i]  = timer_q[i] == LIM;
    end
  end
  // state registers with synchronous active-low reset; a reset mid-count drops the pending change silently
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      x_out_q  <= RST_VAL;
      x_rise_q <= '0;
      x_fall_q <= '0;
      glitch_q <= '0;
      stuck_q  <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      x_out_q  <= x_out_d;
      x_rise_q <= x_rise_d;
      x_fall_q <= x_fall_d;
      glitch_q <= glitch_d;
      stuck_q  <= stuck_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
    end
  end
  assign x_out  = x_out_q;
  assign x_rise = x_rise_q;
  assign x_fall = x_fall_q;
  assign glitch = glitch_q;
  assign stuck  = stuck_q;
endmodule

// File: tb/tb_sensor_debounce_sync.sv
// tb_sensor_debounce_sync: directed scenarios plus randomized run against a behavioural reference model
module tb_sensor_debounce_sync;
  localparam int N = 5, DEB = 4, LIM = 20;
  logic clk = 0, rst = 0, stuck_en = 0;
  logic [N-1:0] x_raw = '0, stuck_clr = '0;
  logic [N-1:0] x_out, x_rise, x_fall, glitch, stuck;
  int errors = 0, checks = 0;
  logic [N-1:0] m_s1, m_s2, m_x, m_nx, m_rise, m_fall, m_gl, m_st;
  int m_run [N];
  int m_tmr [N];

  always #5 clk = ~clk;

  sensor_debounce_sync #(
    .N_CH(N), .DEB_CYCLES(DEB), .DEB_W(8), .STUCK_LIMIT(LIM), .STUCK_W(16), .RST_VAL(5'b0)
  ) dut (
    .clk(clk), .rst(rst), .x_raw(x_raw), .stuck_en(stuck_en), .stuck_clr(stuck_clr),
    .x_out(x_out), .x_rise(x_rise), .x_fall(x_fall), .glitch(glitch), .stuck(stuck)
  );

  // reference: raw seen two edges late; a level is accepted once DEB consecutive late samples disagree with it
  always @(posedge clk) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_x = '0;
      m_rise = '0; m_fall = '0; m_gl = '0; m_st = '0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_tmr[i] = 0; end
    end else begin
      m_nx = m_x;
      for (int i = 0; i < N; i++) begin
        m_rise[i] = 0; m_fall[i] = 0; m_gl[i] = 0;
        if (m_s2[i] == m_x[i]) begin
          m_gl[i] = m_run[i] > 0;
          m_run[i] = 0;
        end else if (m_run[i] + 1 == DEB) begin
          m_nx[i] = m_s2[i];
          m_rise[i] = m_s2[i];
          m_fall[i] = !m_s2[i];
          m_run[i] = 0;
        end else m_run[i] = m_run[i] + 1;
        m_st[i] = m_tmr[i] == LIM;
        if (!stuck_en || stuck_clr[i] || m_nx[i] != m_x[i]) m_tmr[i] = 0;
        else if (m_tmr[i] < LIM) m_tmr[i] = m_tmr[i] + 1;
      end
      m_x = m_nx;
      m_s2 = m_s1;
      m_s1 = x_raw;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 0; x_raw = '1; stuck_en = 0; stuck_clr = '0;
    tick(3);
    checks++;
    if ({x_out, x_rise, x_fall, glitch, stuck} !== '0) begin
      errors++; $display("FAIL reset_hold: outputs=%b required all zero", {x_out, x_rise, x_fall, glitch, stuck});
    end
    rst = 1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (x_out !== (e >= 6 ? 5'b11111 : 5'b0)) begin
        errors++; $display("FAIL reset_release_out e%0d: got %b want %b", e, x_out, (e >= 6 ? 5'b11111 : 5'b0));
      end
      checks++;
      if (x_rise !== (e == 6 ? 5'b11111 : 5'b0)) begin
        errors++; $display("FAIL reset_release_rise e%0d: got %b want %b", e, x_rise, (e == 6 ? 5'b11111 : 5'b0));
      end
    end
  endtask

  task automatic test_latency;
    rst = 0; x_raw = '0; stuck_en = 0; tick(2); rst = 1; tick(2);
    x_raw = 5'b00001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (x_out !== (e >= 6 ? 5'b00001 : 5'b0) || x_rise !== (e == 6 ? 5'b00001 : 5'b0)) begin
        errors++; $display("FAIL latency_rise e%0d: out=%b rise=%b want out=%b rise=%b", e, x_out, x_rise,
                           (e >= 6 ? 5'b00001 : 5'b0), (e == 6 ? 5'b00001 : 5'b0));
      end
    end
    x_raw = 5'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (x_out !== (e >= 6 ? 5'b0 : 5'b00001) || x_fall !== (e == 6 ? 5'b00001 : 5'b0)) begin
        errors++; $display("FAIL latency_fall e%0d: out=%b fall=%b want out=%b fall=%b", e, x_out, x_fall,
                           (e >= 6 ? 5'b0 : 5'b00001), (e == 6 ? 5'b00001 : 5'b0));
      end
    end
  endtask

  task automatic test_glitch;
    rst = 0; x_raw = '0; stuck_en = 0; tick(2); rst = 1; tick(2);
    x_raw = 5'b00100;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) x_raw = '0;
      tick();
      checks++;
      if (x_out !== '0 || x_rise !== '0 || glitch !== (e == 6 ? 5'b00100 : 5'b0)) begin
        errors++; $display("FAIL glitch e%0d: out=%b rise=%b glitch=%b want glitch=%b", e, x_out, x_rise, glitch,
                           (e == 6 ? 5'b00100 : 5'b0));
      end
    end
  endtask

  task automatic test_reset_midcount;
    rst = 0; x_raw = '0; stuck_en = 0; tick(2); rst = 1; tick(2);
    x_raw = 5'b00010;
    tick(2);
    rst = 0;
    tick();
    checks++;
    if ({x_out, x_rise, x_fall, glitch, stuck} !== '0) begin
      errors++; $display("FAIL midcount_reset: outputs=%b required all zero", {x_out, x_rise, x_fall, glitch, stuck});
    end
    rst = 1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (x_out !== (e >= 6 ? 5'b00010 : 5'b0) || x_rise !== (e == 6 ? 5'b00010 : 5'b0) || glitch !== '0) begin
        errors++; $display("FAIL midcount_restart e%0d: out=%b rise=%b glitch=%b", e, x_out, x_rise, glitch);
      end
    end
  endtask

  task automatic test_stuck;
    rst = 0; x_raw = '0; stuck_en = 0; stuck_clr = '0; tick(2);
    rst = 1; stuck_en = 1;
    for (int e = 1; e <= 21; e++) begin
      tick();
      checks++;
      if (stuck !== (e == 21 ? 5'b11111 : 5'b0)) begin
        errors++; $display("FAIL stuck_assert e%0d: got %b want %b", e, stuck, (e == 21 ? 5'b11111 : 5'b0));
      end
    end
    stuck_clr = 5'b01000;
    for (int e = 1; e <= 22; e++) begin
      if (e == 2) stuck_clr = '0;
      tick();
      checks++;
      if (stuck !== (e == 1 || e == 22 ? 5'b11111 : 5'b10111)) begin
        errors++; $display("FAIL stuck_clear e%0d: got %b want %b", e, stuck, (e == 1 || e == 22 ? 5'b11111 : 5'b10111));
      end
    end
    stuck_en = 0;
    tick(2);
    checks++;
    if (stuck !== '0) begin
      errors++; $display("FAIL stuck_disable: got %b want 00000", stuck);
    end
  endtask

  task automatic test_simultaneous;
    rst = 0; x_raw = '0; stuck_en = 0; stuck_clr = '0; tick(2);
    rst = 1; stuck_en = 1;
    x_raw = 5'b10001;
    for (int e = 1; e <= 27; e++) begin
      stuck_clr = (e == 6) ? 5'b10000 : 5'b0;
      tick();
      checks++;
      if (x_out !== (e >= 6 ? 5'b10001 : 5'b0) || x_rise !== (e == 6 ? 5'b10001 : 5'b0) || glitch !== '0) begin
        errors++; $display("FAIL simultaneous e%0d: out=%b rise=%b glitch=%b", e, x_out, x_rise, glitch);
      end
      checks++;
      if (stuck !== (e >= 27 ? 5'b11111 : e >= 21 ? 5'b01110 : 5'b0)) begin
        errors++; $display("FAIL simultaneous_stuck e%0d: got %b want %b", e, stuck,
                           (e >= 27 ? 5'b11111 : e >= 21 ? 5'b01110 : 5'b0));
      end
    end
    stuck_en = 0;
  endtask

  task automatic test_random;
    logic [N-1:0] flip, clr;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        flip[i] = $urandom_range(0, 9) == 0;
        clr[i]  = $urandom_range(0, 39) == 0;
      end
      x_raw = x_raw ^ flip;
      stuck_clr = clr;
      stuck_en = $urandom_range(0, 29) != 0;
      rst = $urandom_range(0, 99) != 0;
      tick();
      checks++;
      if (x_out !== m_x) begin errors++; $display("FAIL rand_out c%0d: got %b want %b", c, x_out, m_x); end
      checks++;
      if (x_rise !== m_rise) begin errors++; $display("FAIL rand_rise c%0d: got %b want %b", c, x_rise, m_rise); end
      checks++;
      if (x_fall !== m_fall) begin errors++; $display("FAIL rand_fall c%0d: got %b want %b", c, x_fall, m_fall); end
      checks++;
      if (glitch !== m_gl) begin errors++; $display("FAIL rand_glitch c%0d: got %b want %b", c, glitch, m_gl); end
      checks++;
      if (stuck !== m_st) begin errors++; $display("FAIL rand_stuck c%0d: got %b want %b", c, stuck, m_st); end
    end
    rst = 1;
    stuck_clr = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_reset_midcount();
    test_stuck();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
